// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs decoded fields into I/S/B/R instruction words and
// streams them through a two-stage valid/ready pipeline tagged with imem byte addresses.
module instr_encoder #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0,
    parameter int ADDR_STEP = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic [15:0]       enc_count,
    output logic [15:0]       err_count
);

    localparam logic [6:0]        OP_LOAD   = 7'b0000011;
    localparam logic [6:0]        OP_IMM    = 7'b0010011;
    localparam logic [6:0]        OP_STORE  = 7'b0100011;
    localparam logic [6:0]        OP_BRANCH = 7'b1100011;
    localparam logic [6:0]        OP_REG    = 7'b0110011;
    localparam logic [31:0]       NOP_INSTR = 32'h0000_0013;
    localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] STEP_A    = ADDR_W'(ADDR_STEP);
    localparam logic [15:0]       CNT_MAX   = 16'hFFFF;

    // 12-bit signed immediate: bits above bit 11 must replicate the sign
    function automatic logic fits_i(input logic [31:0] imm);
        return (imm[31:11] == {21{imm[11]}});
    endfunction

    // 13-bit signed, even branch offset
    function automatic logic fits_b(input logic [31:0] imm);
        return (imm[31:12] == {20{imm[12]}}) && (imm[0] == 1'b0);
    endfunction

    // Returns {err, instr}; rejected inputs encode as addi x0,x0,0
    function automatic logic [32:0] encode(
        input logic [6:0]  op,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [31:0] imm
    );
        logic [32:0] res;
        res = {1'b1, NOP_INSTR};
        case (op)
            OP_LOAD, OP_IMM: begin
                if (fits_i(imm)) begin
                    res = {1'b0, imm[11:0], rs1, f3, rd, op};
                end else begin
                    res = {1'b1, NOP_INSTR};
                end
            end
            OP_STORE: begin
                if (fits_i(imm)) begin
                    res = {1'b0, imm[11:5], rs2, rs1, f3, imm[4:0], op};
                end else begin
                    res = {1'b1, NOP_INSTR};
                end
            end
            OP_BRANCH: begin
                if (fits_b(imm)) begin
                    res = {1'b0, imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
                end else begin
                    res = {1'b1, NOP_INSTR};
                end
            end
            OP_REG: begin
                res = {1'b0, f7, rs2, rs1, f3, rd, op};
            end
            default: begin
                res = {1'b1, NOP_INSTR};
            end
        endcase
        return res;
    endfunction

    logic              s1_valid_r;
    logic [6:0]        s1_opcode_r;
    logic [4:0]        s1_rd_r;
    logic [4:0]        s1_rs1_r;
    logic [4:0]        s1_rs2_r;
    logic [2:0]        s1_funct3_r;
    logic [6:0]        s1_funct7_r;
    logic [31:0]       s1_imm_r;
    logic              s2_valid_r;
    logic [31:0]       s2_instr_r;
    logic              s2_err_r;
    logic [ADDR_W-1:0] addr_r;
    logic [15:0]       enc_cnt_r;
    logic [15:0]       err_cnt_r;
    logic [32:0]       enc_s;
    logic              s2_load_s;
    logic              accept_s;
    logic              out_hs_s;

    // Handshake qualifiers and the encoded view of the stage-1 fields
    always_comb begin
        s2_load_s = !s2_valid_r || out_ready;
        in_ready  = rst_n && !clear && (!s1_valid_r || s2_load_s);
        accept_s  = in_valid && in_ready;
        out_hs_s  = s2_valid_r && out_ready;
        enc_s     = encode(s1_opcode_r, s1_rd_r, s1_rs1_r, s1_rs2_r,
                           s1_funct3_r, s1_funct7_r, s1_imm_r);
    end

    // Stage 1: capture raw input fields
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_r  <= 1'b0;
            s1_opcode_r <= 7'd0;
            s1_rd_r     <= 5'd0;
            s1_rs1_r    <= 5'd0;
            s1_rs2_r    <= 5'd0;
            s1_funct3_r <= 3'd0;
            s1_funct7_r <= 7'd0;
            s1_imm_r    <= 32'd0;
        end else if (clear) begin
            s1_valid_r <= 1'b0;
        end else if (accept_s) begin
            s1_valid_r  <= 1'b1;
            s1_opcode_r <= in_opcode;
            s1_rd_r     <= in_rd;
            s1_rs1_r    <= in_rs1;
            s1_rs2_r    <= in_rs2;
            s1_funct3_r <= in_funct3;
            s1_funct7_r <= in_funct7;
            s1_imm_r    <= in_imm;
        end else if (s2_load_s) begin
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // Stage 2: encoded word; payload only moves when stage 1 has data, so a stalled word holds
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid_r <= 1'b0;
            s2_instr_r <= 32'd0;
            s2_err_r   <= 1'b0;
        end else if (clear) begin
            s2_valid_r <= 1'b0;
        end else if (s2_load_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_instr_r <= enc_s[31:0];
                s2_err_r   <= enc_s[32];
            end
        end else begin
            s2_valid_r <= s2_valid_r;
        end
    end

    // Output address and saturating good/error word counters
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            addr_r    <= BASE_A;
            enc_cnt_r <= 16'd0;
            err_cnt_r <= 16'd0;
        end else if (out_hs_s) begin
            addr_r <= addr_r + STEP_A;
            if (!s2_err_r) begin
                if (enc_cnt_r != CNT_MAX) begin
                    enc_cnt_r <= enc_cnt_r + 16'd1;
                end
            end else begin
                if (err_cnt_r != CNT_MAX) begin
                    err_cnt_r <= err_cnt_r + 16'd1;
                end
            end
        end else begin
            addr_r <= addr_r;
        end
    end

    assign out_valid = s2_valid_r;
    assign out_instr = s2_instr_r;
    assign out_err   = s2_err_r;
    assign out_addr  = addr_r;
    assign enc_count = enc_cnt_r;
    assign err_count = err_cnt_r;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-encoded RV32I words, error placeholders,
// backpressure, clear/reset flush and address wrap on a 4-bit-address instance.
module tb_instr_encoder;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [7:0]  out_addr;
    logic        out_err;
    logic [15:0] enc_count;
    logic [15:0] err_count;

    logic        in_ready4;
    logic        out_valid4;
    logic [31:0] out_instr4;
    logic [3:0]  out_addr4;
    logic        out_err4;
    logic [15:0] enc_count4;
    logic [15:0] err_count4;

    int          checks;
    int          errors;
    logic [32:0] exp_q[$];
    logic [7:0]  exp_addr;
    logic [3:0]  exp_addr4;
    logic [15:0] exp_enc;
    logic [15:0] exp_err;

    instr_encoder #(.ADDR_W(8), .BASE_ADDR(0), .ADDR_STEP(4)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .out_err(out_err),
        .enc_count(enc_count), .err_count(err_count)
    );

    instr_encoder #(.ADDR_W(4), .BASE_ADDR(0), .ADDR_STEP(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready4),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid4), .out_ready(out_ready), .out_instr(out_instr4),
        .out_addr(out_addr4), .out_err(out_err4),
        .enc_count(enc_count4), .err_count(err_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush_model();
        exp_q.delete();
        exp_addr  = 8'h00;
        exp_addr4 = 4'h0;
        exp_enc   = 16'd0;
        exp_err   = 16'd0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        flush_model();
    endtask

    // Offer one set of fields until accepted (bounded), then queue its expected word
    task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm, input logic [31:0] ei, input logic ee);
        logic acc;
        in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm;
        in_valid  = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (acc) exp_q.push_back({ee, ei});
        else     check_value("send_timeout", 32'd0, 32'd1);
    endtask

    // Output scoreboard: every handshake must match the next expected word, address and counts
    always @(negedge clk) begin
        if (rst_n && !clear && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_value("unexpected_word", out_instr, 32'hxxxxxxxx);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                check_value("sb_instr", out_instr, e[31:0]);
                check_value("sb_err", {31'd0, out_err}, {31'd0, e[32]});
                check_value("sb_addr", {24'd0, out_addr}, {24'd0, exp_addr});
                check_value("sb_addr4", {28'd0, out_addr4}, {28'd0, exp_addr4});
                check_value("sb_enc_cnt", {16'd0, enc_count}, {16'd0, exp_enc});
                check_value("sb_err_cnt", {16'd0, err_count}, {16'd0, exp_err});
                exp_addr  = exp_addr + 8'd4;
                exp_addr4 = exp_addr4 + 4'd4;
                if (e[32]) exp_err = exp_err + 16'd1;
                else       exp_enc = exp_enc + 16'd1;
            end
        end
    end

    initial begin
        checks = 0; errors = 0;
        flush_model();
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_opcode = 7'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0;
        in_funct3 = 3'd0; in_funct7 = 7'd0; in_imm = 32'd0;
        tick();
        in_valid = 1'b1;
        @(negedge clk);
        check_value("rst_in_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        tick();
        check_value("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_value("rst_out_instr", out_instr, 32'd0);
        check_value("rst_out_err", {31'd0, out_err}, 32'd0);
        check_value("rst_out_addr", {24'd0, out_addr}, 32'd0);
        check_value("rst_counts", {enc_count, err_count}, 32'd0);
        rst_n = 1'b1;
        tick();
        check_value("idle_in_ready", {31'd0, in_ready}, 32'd1);

        // addi x1,x2,-1 : two-cycle latency
        out_ready = 1'b1;
        send(7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF1_0093, 1'b0);
        check_value("t1_lat1", {31'd0, out_valid}, 32'd0);
        tick();
        check_value("t1_valid", {31'd0, out_valid}, 32'd1);
        check_value("t1_instr", out_instr, 32'hFFF1_0093);
        check_value("t1_addr", {24'd0, out_addr}, 32'h0);
        tick();
        check_value("t1_enc_cnt", {16'd0, enc_count}, 32'd1);
        check_value("t1_idle", {31'd0, out_valid}, 32'd0);

        // sw x5,8(x2) ; beq x1,x2,-4 back-to-back
        do_clear();
        check_value("clr_counts", {enc_count, err_count}, 32'd0);
        check_value("clr_addr", {24'd0, out_addr}, 32'd0);
        send(7'b0100011, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'd8, 32'h0051_2423, 1'b0);
        send(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE20_8EE3, 1'b0);
        check_value("t2_sw", out_instr, 32'h0051_2423);
        check_value("t2_sw_addr", {24'd0, out_addr}, 32'h0);
        tick();
        check_value("t2_beq", out_instr, 32'hFE20_8EE3);
        check_value("t2_beq_addr", {24'd0, out_addr}, 32'h4);
        check_value("t2_beq_valid", {31'd0, out_valid}, 32'd1);
        tick();

        // three rejected inputs become NOP placeholders
        do_clear();
        send(7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h0000_0013, 1'b1);
        send(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 32'h0000_0013, 1'b1);
        send(7'b1111111, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0, 32'h0000_0013, 1'b1);
        tick(); tick(); tick();
        check_value("t3_err_cnt", {16'd0, err_count}, 32'd3);
        check_value("t3_enc_cnt", {16'd0, enc_count}, 32'd0);
        check_value("t3_addr", {24'd0, out_addr}, 32'hC);

        // backpressure: two words fill the pipe, third waits
        do_clear();
        out_ready = 1'b0;
        send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'b0000000, 32'h1234_5678, 32'h0020_81B3, 1'b0);
        send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'b0100000, 32'd0, 32'h4020_81B3, 1'b0);
        in_opcode = 7'b0000011; in_rd = 5'd4; in_rs1 = 5'd5; in_funct3 = 3'd2;
        in_imm = 32'hFFFF_FFF8; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_value("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check_value("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check_value("bp_hold_instr", out_instr, 32'h0020_81B3);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(7'b0000011, 5'd4, 5'd5, 5'd0, 3'd2, 7'd0, 32'hFFFF_FFF8, 32'hFF82_A203, 1'b0);
        tick(); tick(); tick();
        check_value("bp_enc_cnt", {16'd0, enc_count}, 32'd3);

        // five words: 4-bit address instance wraps 0xC -> 0x0
        do_clear();
        for (int k = 0; k < 5; k++) begin
            send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, k, (k << 20) | 32'h93, 1'b0);
        end
        tick(); tick(); tick();
        check_value("wrap_addr4", {28'd0, out_addr4}, 32'h4);
        check_value("wrap_addr8", {24'd0, out_addr}, 32'h14);

        // clear with both stages full and an input offered
        out_ready = 1'b0;
        send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0093, 1'b0);
        send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd6, 32'h0060_0093, 1'b0);
        in_valid = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        check_value("clr_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        clear = 1'b0;
        in_valid = 1'b0;
        flush_model();
        check_value("clr_out_valid", {31'd0, out_valid}, 32'd0);
        check_value("clr_counts2", {enc_count, err_count}, 32'd0);
        check_value("clr_addr2", {24'd0, out_addr}, 32'd0);
        tick(); tick();
        check_value("clr_nothing_taken", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7, 32'h0070_0093, 1'b0);
        tick();
        check_value("post_clr_instr", out_instr, 32'h0070_0093);
        check_value("post_clr_addr", {24'd0, out_addr}, 32'h0);
        tick();

        // reset mid-stream zeroes the output word
        out_ready = 1'b0;
        send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9, 32'h0090_0093, 1'b0);
        tick();
        check_value("pre_rst_instr", out_instr, 32'h0090_0093);
        rst_n = 1'b0;
        tick();
        flush_model();
        check_value("mid_rst_instr", out_instr, 32'd0);
        check_value("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check_value("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
        check_value("drain", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
